// File: rtl/dpi_call_serializer_pkg.sv
// dpi_ser_pkg: shared FSM state type and saturating counter helper for the call serializer
package dpi_ser_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} dpi_ser_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dpi_call_serializer_if.sv
// dpi_call_serializer_if: requester, service and status signals of the call serializer
interface dpi_call_serializer_if #(
  parameter int NREQ  = 2,
  parameter int ARG_W = 32,
  parameter int RES_W = 32,
  parameter int CNT_W = 16
);
  localparam int SRC_W = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ARG_W-1:0] req_arg;
  logic [NREQ-1:0]       req_ready;
  logic                  call_valid;
  logic [ARG_W-1:0]      call_arg;
  logic [SRC_W-1:0]      call_src;
  logic                  call_ready;
  logic                  done_valid;
  logic [RES_W-1:0]      done_result;
  logic [NREQ-1:0]       rsp_valid;
  logic [RES_W-1:0]      rsp_result;
  logic                  busy;
  logic [CNT_W-1:0]      completed;
  logic [CNT_W-1:0]      collisions;
  logic [CNT_W-1:0]      timeouts;

  modport slave (
    input  req_valid, req_arg, call_ready, done_valid, done_result,
    output req_ready, call_valid, call_arg, call_src, rsp_valid, rsp_result,
           busy, completed, collisions, timeouts
  );

  modport master (
    output req_valid, req_arg, call_ready, done_valid, done_result,
    input  req_ready, call_valid, call_arg, call_src, rsp_valid, rsp_result,
           busy, completed, collisions, timeouts
  );

endinterface

// File: rtl/dpi_call_serializer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  logic             found;
  logic [IDX_W-1:0] j;

  assign any_o = |req_i;

  // scan positions ptr, ptr+1, ... modulo NREQ and keep the first active one
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDX_W'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/dpi_call_serializer.sv
// dpi_call_serializer: funnels requester calls one at a time onto a non-reentrant service port
module dpi_call_serializer
  import dpi_ser_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ARG_W   = 32,
  parameter int RES_W   = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst_n,
  dpi_call_serializer_if.slave bus
);
  localparam int SRC_W = $clog2(NREQ);
  localparam int TMR_W = $clog2(TIMEOUT);

  dpi_ser_state_e   state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ARG_W-1:0] call_arg_q, call_arg_d;
  logic [SRC_W-1:0] call_src_q, call_src_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d;
  logic [NREQ-1:0]  req_ready_q, req_ready_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic             call_valid_q, call_valid_d;
  logic             busy_q, busy_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] completed_q, completed_d;
  logic [CNT_W-1:0] collisions_q, collisions_d;
  logic [CNT_W-1:0] timeouts_q, timeouts_d;
  logic [NREQ-1:0]  gnt;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             collide;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(SRC_W)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // a completion outside WAIT or an accept outside ISSUE is a protocol violation
  assign collide = (bus.done_valid && state_q != WAIT) || (bus.call_ready && state_q != ISSUE);

  // state and every output register; reset abandons any call in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      call_arg_q   <= '0;
      call_src_q   <= '0;
      rsp_result_q <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      call_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      timer_q      <= '0;
      completed_q  <= '0;
      collisions_q <= '0;
      timeouts_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      call_arg_q   <= call_arg_d;
      call_src_q   <= call_src_d;
      rsp_result_q <= rsp_result_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      call_valid_q <= call_valid_d;
      busy_q       <= busy_d;
      timer_q      <= timer_d;
      completed_q  <= completed_d;
      collisions_q <= collisions_d;
      timeouts_q   <= timeouts_d;
    end
  end

  // next state, counters, and outputs precomputed from the next state so they leave registered
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    call_arg_d   = call_arg_q;
    call_src_d   = call_src_q;
    rsp_result_d = rsp_result_q;
    timer_d      = timer_q;
    completed_d  = completed_q;
    timeouts_d   = timeouts_q;
    collisions_d = collide ? CNT_W'(sat_inc(32'(collisions_q), CNT_W)) : collisions_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        state_d    = ISSUE;
        rr_ptr_d   = (gnt_idx == SRC_W'(NREQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
        call_arg_d = bus.req_arg[gnt_idx*ARG_W +: ARG_W];
        call_src_d = gnt_idx;
      end
      ISSUE: if (bus.call_ready) begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: if (bus.done_valid) begin
        state_d      = RESP;
        rsp_result_d = bus.done_result;
      end else if (timer_q == TMR_W'(TIMEOUT - 2)) begin
        state_d    = IDLE;
        timeouts_d = CNT_W'(sat_inc(32'(timeouts_q), CNT_W));
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
      RESP: begin
        state_d     = IDLE;
        completed_d = CNT_W'(sat_inc(32'(completed_q), CNT_W));
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_q == IDLE) ? gnt : '0;
    call_valid_d = state_d == ISSUE;
    rsp_valid_d  = (state_d == RESP) ? (NREQ'(1) << call_src_q) : '0;
    busy_d       = state_d != IDLE;
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.call_valid = call_valid_q;
  assign bus.call_arg   = call_arg_q;
  assign bus.call_src   = call_src_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = busy_q;
  assign bus.completed  = completed_q;
  assign bus.collisions = collisions_q;
  assign bus.timeouts   = timeouts_q;

endmodule

// File: tb/tb_dpi_call_serializer.sv
// tb_dpi_call_serializer: table-driven and sequence checks with a response scoreboard
module tb_dpi_call_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dpi_call_serializer_if #(.NREQ(2), .ARG_W(32), .RES_W(32), .CNT_W(16)) u_if ();
  dpi_call_serializer_if #(.NREQ(2), .ARG_W(32), .RES_W(32), .CNT_W(2))  u_if2 ();

  dpi_call_serializer #(.NREQ(2), .ARG_W(32), .RES_W(32), .CNT_W(16), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  dpi_call_serializer #(.NREQ(2), .ARG_W(32), .RES_W(32), .CNT_W(2), .TIMEOUT(8)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if2)
  );

  typedef struct {
    logic [1:0]  v;
    logic [31:0] r;
  } rsp_t;

  typedef struct {
    logic [1:0]  rv;
    int          exp_src;
    logic [31:0] res;
  } vec_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && u_if.rsp_valid !== 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got=%b exp=none", u_if.rsp_valid);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_valid", 32'(u_if.rsp_valid), 32'(mon_e.v));
        check("rsp_result", u_if.rsp_result, mon_e.r);
      end
    end
  end

  task automatic wait_call();
    int n = 0;
    while (u_if.call_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("call_valid_wait", 32'(u_if.call_valid), 32'd1);
  endtask

  task automatic serve(input int exp_src, input logic [31:0] exp_arg, input logic [31:0] res, input bit drop);
    wait_call();
    check("call_src", 32'(u_if.call_src), 32'(exp_src));
    check("call_arg", u_if.call_arg, exp_arg);
    check("req_ready", 32'(u_if.req_ready), 32'(1) << exp_src);
    if (drop) u_if.req_valid = 2'b00;
    u_if.call_ready = 1'b1;
    @(negedge clk);
    u_if.call_ready = 1'b0;
    check("call_valid_in_wait", 32'(u_if.call_valid), 32'd0);
    u_if.done_valid  = 1'b1;
    u_if.done_result = res;
    exp_q.push_back('{2'(1 << exp_src), res});
    @(negedge clk);
    u_if.done_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    u_if.req_valid = '0;  u_if.req_arg = '0;  u_if.call_ready = 1'b0;
    u_if.done_valid = 1'b0;  u_if.done_result = '0;
    u_if2.req_valid = '0; u_if2.req_arg = '0; u_if2.call_ready = 1'b0;
    u_if2.done_valid = 1'b0; u_if2.done_result = '0;
    vecs[0] = '{2'b11, 1, 32'h100};
    vecs[1] = '{2'b10, 1, 32'h101};
    vecs[2] = '{2'b01, 0, 32'h102};
    vecs[3] = '{2'b01, 0, 32'h103};
    vecs[4] = '{2'b11, 1, 32'h104};
    vecs[5] = '{2'b11, 0, 32'h105};
    vecs[6] = '{2'b10, 1, 32'h106};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", 32'(u_if.busy), 0);
    check("rst_call_valid", 32'(u_if.call_valid), 0);
    check("rst_req_ready", 32'(u_if.req_ready), 0);
    check("rst_rsp_valid", 32'(u_if.rsp_valid), 0);
    check("rst_call_arg", u_if.call_arg, 0);
    check("rst_call_src", 32'(u_if.call_src), 0);
    check("rst_rsp_result", u_if.rsp_result, 0);
    check("rst_completed", 32'(u_if.completed), 0);
    check("rst_collisions", 32'(u_if.collisions), 0);
    check("rst_timeouts", 32'(u_if.timeouts), 0);

    // single call from requester 0, minimum latency, done two cycles after accept
    u_if.req_valid = 2'b01;
    u_if.req_arg   = {32'h0, 32'h11};
    @(negedge clk);
    check("single_req_ready", 32'(u_if.req_ready), 32'b01);
    check("single_call_valid", 32'(u_if.call_valid), 1);
    check("single_call_arg", u_if.call_arg, 32'h11);
    check("single_call_src", 32'(u_if.call_src), 0);
    check("single_busy", 32'(u_if.busy), 1);
    u_if.req_valid  = 2'b00;
    u_if.call_ready = 1'b1;
    @(negedge clk);
    u_if.call_ready = 1'b0;
    check("single_wait_call_valid", 32'(u_if.call_valid), 0);
    @(negedge clk);
    u_if.done_valid  = 1'b1;
    u_if.done_result = 32'h22;
    exp_q.push_back('{2'b01, 32'h22});
    @(negedge clk);
    u_if.done_valid = 1'b0;
    @(negedge clk);
    check("single_completed", 32'(u_if.completed), 1);
    check("single_collisions", 32'(u_if.collisions), 0);
    check("single_idle", 32'(u_if.busy), 0);
    check("single_drained", exp_q.size(), 0);

    // table of independent calls; pointer walks 1,0,0,1,1,0,1 -> 0
    foreach (vecs[i]) begin
      u_if.req_valid = vecs[i].rv;
      u_if.req_arg   = {32'h2000 + 32'(i), 32'h1000 + 32'(i)};
      serve(vecs[i].exp_src, vecs[i].exp_src == 1 ? 32'h2000 + 32'(i) : 32'h1000 + 32'(i), vecs[i].res, 1'b1);
    end
    @(negedge clk);
    check("table_completed", 32'(u_if.completed), 8);

    // fairness: both held for six calls
    u_if.req_valid = 2'b11;
    u_if.req_arg   = {32'hB1, 32'hA0};
    for (int k = 0; k < 6; k++)
      serve(k % 2, (k % 2) ? 32'hB1 : 32'hA0, 32'h300 + 32'(k), k == 5);
    @(negedge clk);
    check("fair_completed", 32'(u_if.completed), 14);
    check("fair_collisions", 32'(u_if.collisions), 0);

    // timeout: service never completes
    u_if.req_valid = 2'b01;
    u_if.req_arg   = {32'h0, 32'h77};
    wait_call();
    check("to_call_src", 32'(u_if.call_src), 0);
    u_if.req_valid  = 2'b00;
    u_if.call_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      u_if.call_ready = 1'b0;
      cyc++;
    end while (u_if.busy && cyc < 20);
    check("to_cycles", cyc, 8);
    check("to_timeouts", 32'(u_if.timeouts), 1);
    check("to_completed", 32'(u_if.completed), 14);
    check("to_no_rsp", exp_q.size(), 0);

    // collisions: done in IDLE, done+ready together in IDLE, ready in WAIT
    u_if.done_valid = 1'b1;
    @(negedge clk);
    u_if.done_valid = 1'b0;
    check("col_idle_done", 32'(u_if.collisions), 1);
    check("col_idle_state", 32'(u_if.busy), 0);
    u_if.done_valid = 1'b1;
    u_if.call_ready = 1'b1;
    @(negedge clk);
    u_if.done_valid = 1'b0;
    u_if.call_ready = 1'b0;
    check("col_both_once", 32'(u_if.collisions), 2);
    u_if.req_valid = 2'b01;
    u_if.req_arg   = {32'h0, 32'h55};
    wait_call();
    check("col_call_src", 32'(u_if.call_src), 0);
    u_if.req_valid  = 2'b00;
    u_if.call_ready = 1'b1;
    @(negedge clk);
    u_if.call_ready = 1'b0;
    @(negedge clk);
    u_if.call_ready = 1'b1;
    @(negedge clk);
    u_if.call_ready = 1'b0;
    check("col_wait_ready", 32'(u_if.collisions), 3);
    check("col_wait_busy", 32'(u_if.busy), 1);
    check("col_wait_call_valid", 32'(u_if.call_valid), 0);
    u_if.done_valid  = 1'b1;
    u_if.done_result = 32'h33;
    exp_q.push_back('{2'b01, 32'h33});
    @(negedge clk);
    u_if.done_valid = 1'b0;
    @(negedge clk);
    check("col_completed", 32'(u_if.completed), 15);
    check("col_final", 32'(u_if.collisions), 3);

    // reset in the middle of WAIT
    u_if.req_valid = 2'b01;
    u_if.req_arg   = {32'h0, 32'h99};
    wait_call();
    u_if.req_valid  = 2'b00;
    u_if.call_ready = 1'b1;
    @(negedge clk);
    u_if.call_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(u_if.busy), 0);
    check("mid_rst_call_valid", 32'(u_if.call_valid), 0);
    check("mid_rst_call_arg", u_if.call_arg, 0);
    check("mid_rst_rsp_result", u_if.rsp_result, 0);
    check("mid_rst_completed", 32'(u_if.completed), 0);
    check("mid_rst_collisions", 32'(u_if.collisions), 0);
    check("mid_rst_timeouts", 32'(u_if.timeouts), 0);
    u_if.done_valid  = 1'b1;
    u_if.done_result = 32'h44;
    @(negedge clk);
    u_if.done_valid = 1'b0;
    check("mid_rst_late_done", 32'(u_if.collisions), 1);
    check("mid_rst_no_rsp", exp_q.size(), 0);
    u_if.req_valid = 2'b11;
    u_if.req_arg   = {32'hD1, 32'hD0};
    serve(0, 32'hD0, 32'h400, 1'b1);
    @(negedge clk);
    check("mid_rst_after_completed", 32'(u_if.completed), 1);

    // saturation on the narrow-counter instance
    u_if2.done_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("sat_at_3", 32'(u_if2.collisions), 3);
    repeat (2) @(negedge clk);
    u_if2.done_valid = 1'b0;
    @(negedge clk);
    check("sat_held", 32'(u_if2.collisions), 3);
    check("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
